udp_tx_framer: RTL and testbench

UDP_TX_FRAMER -- requirements
Module: udp_tx_framer

---
 rtl/udp_tx_pkg.sv | 15 +
 rtl/udp_tx_framer_if.sv | 27 ++
 rtl/ip_hdr_csum.sv | 29 ++
 rtl/udp_tx_framer.sv | 162 ++++++++++++++++
 tb/tb_udp_tx_framer.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/udp_tx_pkg.sv
// Shared constants and state encoding for the UDP transmit framer.
package udp_tx_pkg;
   localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
   localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
   localparam logic [15:0] IP_VER_IHL    = 16'h4500;  // version 4, IHL 5, TOS 0
   localparam logic [15:0] IP_FLAGS_DF   = 16'h4000;  // don't-fragment, offset 0
   localparam logic [15:0] IP_UDP_HDRS   = 16'd28;    // IPv4 (20) + UDP (8)
   localparam logic [15:0] UDP_HDR_BYTES = 16'd8;
   localparam int          HDR_LEN       = 42;        // Ethernet + IPv4 + UDP header bytes
   localparam int          MIN_FRAME     = 60;        // minimum frame length without FCS
   localparam int          GAP_LEN       = 12;
   localparam int          CSUM_CYC      = 4;

   typedef enum logic [2:0] {IDLE, CSUM, REQ, HDR, PLD, PAD, GAP} txState_t;
endpackage

// File: rtl/udp_tx_framer_if.sv
// Frame request, payload fetch, arbiter handshake and byte stream of the UDP framer.
interface udp_tx_framer_if;
   logic [47:0] LocalMAC, RemoteMAC;
   logic [31:0] LocalIP, RemoteIP;
   logic [15:0] LocalPort, RemotePort;
   logic        Start;
   logic [10:0] PayloadLen;
   logic        Busy, ErrLen;
   logic        PldRd;
   logic [7:0]  PldData;
   logic        ReqOut, ReqConfirm;
   logic        ValOut, SoFOut, EoFOut;
   logic [7:0]  DataOut;

   // framer side
   modport master (
      input  LocalMAC, RemoteMAC, LocalIP, RemoteIP, LocalPort, RemotePort,
      input  Start, PayloadLen, PldData, ReqConfirm,
      output Busy, ErrLen, PldRd, ReqOut, ValOut, SoFOut, EoFOut, DataOut
   );
   // environment side
   modport slave (
      output LocalMAC, RemoteMAC, LocalIP, RemoteIP, LocalPort, RemotePort,
      output Start, PayloadLen, PldData, ReqConfirm,
      input  Busy, ErrLen, PldRd, ReqOut, ValOut, SoFOut, EoFOut, DataOut
   );
endinterface

// File: rtl/ip_hdr_csum.sv
// IPv4 header checksum over nine 16-bit words (checksum field excluded),
// spread across four steps: two partial sums, then two end-around folds.
import udp_tx_pkg::*;

module ip_hdr_csum (
   input  logic            Clk,
   input  logic            nRst,
   input  logic            en,
   input  logic [1:0]      step,
   input  logic [8:0][15:0] words,
   output logic [15:0]     csum
);
   logic [19:0] acc;

   // step-sequenced accumulate, fold, fold-and-invert
   always_ff @(posedge Clk or negedge nRst) begin
      if (!nRst) begin
         acc  <= '0;
         csum <= '0;
      end else if (en) begin
         case (step)
            2'd0: acc <= 20'(words[0]) + 20'(words[1]) + 20'(words[2]) + 20'(words[3]) + 20'(words[4]);
            2'd1: acc <= acc + 20'(words[5]) + 20'(words[6]) + 20'(words[7]) + 20'(words[8]);
            2'd2: acc <= 20'({1'b0, acc[15:0]} + {13'd0, acc[19:16]});
            2'd3: csum <= ~(acc[15:0] + {15'd0, acc[16]});
         endcase
      end
   end
endmodule

// File: rtl/udp_tx_framer.sv
// UDP/IPv4/Ethernet transmit framer: header build, checksum, arbiter request,
// payload streaming and inter-frame gap.
// Optional feature macro UDP_TX_MIN_PAD_EN: zero-pad short frames to 60 bytes.
import udp_tx_pkg::*;

module udp_tx_framer #(
   parameter logic [7:0] TTL     = 8'd64,
   parameter int         MAX_PLD = 1472
) (
   input logic             Clk,
   input logic             nRst,
   udp_tx_framer_if.master bus
);
   localparam logic [10:0] MAX_LEN = 11'(MAX_PLD);

   txState_t    state, nextState;
   logic [10:0] pos, posNext;
   logic [47:0] remMac, locMac;
   logic [31:0] locIp, remIp;
   logic [15:0] locPort, remPort;
   logic [10:0] len;
   logic [15:0] frameId, csum, totLen, udpLen;
   logic        errLen, lenOk, accept, pldLast, padLast, needPad;
   logic [8:0][15:0]       csumWords;
   logic [HDR_LEN*8-1:0]   hdrVec, hdrShift;
   logic        valOut, sofOut, eofOut, pldRd, reqOut;
   logic [7:0]  dataOut;

   assign lenOk   = (bus.PayloadLen != 11'd0) && (bus.PayloadLen <= MAX_LEN);
   assign accept  = (state == IDLE) && bus.Start && lenOk;
   assign totLen  = IP_UDP_HDRS + {5'd0, len};
   assign udpLen  = UDP_HDR_BYTES + {5'd0, len};
   assign pldLast = pos == (11'(HDR_LEN - 1) + len);
   assign padLast = pos == 11'(MIN_FRAME - 1);
`ifdef UDP_TX_MIN_PAD_EN
   assign needPad = len < 11'(MIN_FRAME - HDR_LEN);
`else
   assign needPad = 1'b0;
`endif

   assign csumWords = {IP_VER_IHL, totLen, frameId, IP_FLAGS_DF, TTL, IP_PROTO_UDP,
                       locIp[31:16], locIp[15:0], remIp[31:16], remIp[15:0]};

   ip_hdr_csum uCsum (
      .Clk   (Clk),
      .nRst  (nRst),
      .en    (state == CSUM),
      .step  (pos[1:0]),
      .words (csumWords),
      .csum  (csum)
   );

   // header image, MSB first; byte 'pos' is shifted to the top
   assign hdrVec = {remMac, locMac, ETH_TYPE_IPV4, IP_VER_IHL, totLen, frameId, IP_FLAGS_DF,
                    TTL, IP_PROTO_UDP, csum, locIp, remIp, locPort, remPort, udpLen, 16'h0000};
   assign hdrShift = hdrVec << {pos, 3'b000};

   // state and byte-position register
   always_ff @(posedge Clk or negedge nRst) begin
      if (!nRst) begin
         state <= IDLE;
         pos   <= '0;
      end else begin
         state <= nextState;
         pos   <= posNext;
      end
   end

   // request capture, reject pulse and frame ID counter
   always_ff @(posedge Clk or negedge nRst) begin
      if (!nRst) begin
         remMac  <= '0; locMac  <= '0;
         locIp   <= '0; remIp   <= '0;
         locPort <= '0; remPort <= '0;
         len     <= '0;
         errLen  <= 1'b0;
         frameId <= '0;
      end else begin
         errLen <= (state == IDLE) && bus.Start && !lenOk;
         if (accept) begin
            remMac  <= bus.RemoteMAC;  locMac  <= bus.LocalMAC;
            locIp   <= bus.LocalIP;    remIp   <= bus.RemoteIP;
            locPort <= bus.LocalPort;  remPort <= bus.RemotePort;
            len     <= bus.PayloadLen;
         end
         if (eofOut) frameId <= frameId + 16'd1;
      end
   end

   // next state and Moore-style outputs (idle outputs are all zero)
   always_comb begin
      nextState = state;
      posNext   = pos + 11'd1;
      valOut    = 1'b0;
      sofOut    = 1'b0;
      eofOut    = 1'b0;
      pldRd     = 1'b0;
      reqOut    = 1'b0;
      dataOut   = 8'h00;
      case (state)
         IDLE: begin
            posNext = '0;
            if (accept) nextState = CSUM;
         end
         CSUM: begin
            if (pos == 11'(CSUM_CYC - 1)) begin
               nextState = REQ;
               posNext   = '0;
            end
         end
         REQ: begin
            reqOut  = 1'b1;
            posNext = '0;
            if (bus.ReqConfirm) nextState = HDR;
         end
         HDR: begin
            valOut  = 1'b1;
            sofOut  = (pos == 11'd0);
            dataOut = hdrShift[HDR_LEN*8-1 -: 8];
            if (pos == 11'(HDR_LEN - 1)) nextState = PLD;
         end
         PLD: begin
            valOut  = 1'b1;
            pldRd   = 1'b1;
            dataOut = bus.PldData;
            if (pldLast) begin
               if (needPad) begin
                  nextState = PAD;
               end else begin
                  eofOut    = 1'b1;
                  nextState = GAP;
                  posNext   = '0;
               end
            end
         end
         PAD: begin
            valOut = 1'b1;
            if (padLast) begin
               eofOut    = 1'b1;
               nextState = GAP;
               posNext   = '0;
            end
         end
         GAP: begin
            if (pos == 11'(GAP_LEN - 1)) begin
               nextState = IDLE;
               posNext   = '0;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   assign bus.Busy    = (state != IDLE);
   assign bus.ErrLen  = errLen;
   assign bus.PldRd   = pldRd;
   assign bus.ReqOut  = reqOut;
   assign bus.ValOut  = valOut;
   assign bus.SoFOut  = sofOut;
   assign bus.EoFOut  = eofOut;
   assign bus.DataOut = dataOut;
endmodule

// File: tb/tb_udp_tx_framer.sv
// Directed bench for udp_tx_framer: vector table plus reset/ID-wrap sequences.
module tb_udp_tx_framer;
   localparam logic [47:0] LMAC  = 48'h02_00_00_00_00_01;
   localparam logic [47:0] RMAC  = 48'h02_11_22_33_44_55;
   localparam logic [31:0] LIP   = 32'hC0A8_0505;   // 192.168.5.5
   localparam logic [31:0] RIP   = 32'hC0A8_050A;   // 192.168.5.10
   localparam logic [15:0] LPORT = 16'h2323;
   localparam logic [15:0] RPORT = 16'h1000;
`ifdef UDP_TX_MIN_PAD_EN
   localparam bit PADON = 1'b1;
`else
   localparam bit PADON = 1'b0;
`endif

   logic clk = 1'b0;
   logic nRst = 1'b0;
   always #4 clk = ~clk;

   udp_tx_framer_if bus();

   udp_tx_framer #(.TTL(8'd64), .MAX_PLD(1472)) dut (
      .Clk  (clk),
      .nRst (nRst),
      .bus  (bus)
   );

   int total = 0;
   int bad   = 0;

   // monitor state (written only by the monitor process)
   logic [7:0] capQ[$];
   int sofCnt = 0, eofCnt = 0, sofIdx = 0, eofIdx = 0;
   int pldRdCnt = 0, pldIdx = 0, overlapCnt = 0, idleBad = 0;

   logic [7:0]  expQ[$];
   logic [15:0] expId;

   function automatic logic [7:0] pldByte(input int i);
      return 8'(i * 7 + 3);
   endfunction

   assign bus.PldData = pldByte(pldIdx);

   // capture the byte stream and payload reads at the falling edge
   always @(negedge clk) begin
      if (bus.ValOut) begin
         if (bus.SoFOut) begin sofCnt++; sofIdx = capQ.size(); end
         if (bus.EoFOut) begin eofCnt++; eofIdx = capQ.size(); end
         capQ.push_back(bus.DataOut);
      end else if (bus.SoFOut || bus.EoFOut || bus.DataOut != 8'h00 || bus.PldRd) begin
         idleBad++;
      end
      if (bus.ValOut && bus.ReqOut) overlapCnt++;
      if (bus.PldRd) begin pldRdCnt++; pldIdx++; end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   function automatic logic [15:0] cap16(input int i);
      return {capQ[i], capQ[i+1]};
   endfunction

   task automatic putN(input logic [47:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) expQ.push_back(v[8*i +: 8]);
   endtask

   // reference frame: header fields, checksum by repeated fold, payload pattern, pad
   task automatic buildExp(input int len, input logic [15:0] id, input int base);
      logic [15:0] w[10];
      int sum;
      logic [15:0] cs;
      w = '{16'h4500, 16'(28 + len), id, 16'h4000, 16'h4011, 16'h0000,
            LIP[31:16], LIP[15:0], RIP[31:16], RIP[15:0]};
      sum = 0;
      foreach (w[i]) sum += int'(w[i]);
      while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
      cs = ~sum[15:0];
      expQ.delete();
      putN(RMAC, 6); putN(LMAC, 6); putN(48'h0800, 2);
      putN(48'h45, 1); putN(48'h00, 1); putN(48'(28 + len), 2); putN(48'(id), 2);
      putN(48'h4000, 2); putN(48'd64, 1); putN(48'h11, 1); putN(48'(cs), 2);
      putN(48'(LIP), 4); putN(48'(RIP), 4);
      putN(48'(LPORT), 2); putN(48'(RPORT), 2); putN(48'(8 + len), 2); putN(48'h0, 2);
      for (int k = 0; k < len; k++) expQ.push_back(pldByte(base + k));
      if (PADON) while (expQ.size() < 60) expQ.push_back(8'h00);
   endtask

   task automatic runErr(input int len);
      logic okv;
      bus.PayloadLen = 11'(len);
      bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      check("errlen_pulse", {30'd0, bus.ErrLen, bus.Busy}, 32'b10);
      okv = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.ErrLen || bus.Busy || bus.ReqOut) okv = 1'b0;
      end
      check("err_quiet", 32'(okv), 32'd1);
   endtask

   task automatic runFrame(input int len, input int grantDly, input int expBytes, output int c0);
      int e0, p0, s0, n;
      logic okv;
      buildExp(len, expId, pldIdx);
      c0 = capQ.size(); e0 = eofCnt; p0 = pldRdCnt; s0 = sofCnt;
      bus.PayloadLen = 11'(len);
      bus.Start = 1'b1;
      tick();
      check("busy_after_start", 32'(bus.Busy), 32'd1);
      bus.PayloadLen = 11'd0;            // Start held high while busy, with an illegal length
      tick();
      bus.Start = 1'b0;
      check("no_errlen_busy", 32'(bus.ErrLen), 32'd0);
      n = 0;
      while (!bus.ReqOut && n < 20) begin tick(); n++; end
      check("req_seen", 32'(bus.ReqOut), 32'd1);
      okv = 1'b1;
      for (int i = 0; i < grantDly; i++) begin
         tick();
         if (!bus.ReqOut || bus.ValOut) okv = 1'b0;
      end
      check("req_hold", 32'(okv), 32'd1);
      bus.ReqConfirm = 1'b1;
      tick();
      bus.ReqConfirm = 1'b0;
      check("sof_after_grant", {29'd0, bus.ValOut, bus.SoFOut, bus.ReqOut}, 32'b110);
      n = 0;
      while (eofCnt == e0 && n < 2000) begin tick(); n++; end
      check("eof_seen", 32'(eofCnt - e0), 32'd1);
      okv = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (!bus.Busy || bus.ValOut) okv = 1'b0;
      end
      tick();
      check("gap", {30'd0, okv, bus.Busy}, 32'b10);
      check("frame_len", 32'(capQ.size() - c0), 32'(expBytes));
      n = 0;
      foreach (expQ[i]) if (c0 + i >= capQ.size() || capQ[c0+i] !== expQ[i]) n++;
      check("frame_bytes", 32'(n), 32'd0);
      check("sof_cnt", 32'(sofCnt - s0), 32'd1);
      check("sof_idx", 32'(sofIdx - c0), 32'd0);
      check("eof_idx", 32'(eofIdx - c0), 32'(expBytes - 1));
      check("pldrd_cnt", 32'(pldRdCnt - p0), 32'(len));
      check("ip_id", 32'(cap16(c0 + 18)), 32'(expId));
      expId = expId + 16'd1;
   endtask

   typedef struct {
      int          len;
      int          grantDly;
      logic        expErr;
      int          expBytes;
      logic [15:0] expTot;
      logic [15:0] expUdp;
      logic [15:0] expCsum;
      logic        chkCsum;
   } vec_t;

   vec_t vecs[7];

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      int c0, n;
      logic okv;
      vecs[0] = '{4,    3,   1'b0, PADON ? 60 : 46, 16'h0020, 16'h000C, 16'hAF6D, 1'b1};
      vecs[1] = '{0,    0,   1'b1, 0,               16'h0000, 16'h0000, 16'h0000, 1'b0};
      vecs[2] = '{1473, 0,   1'b1, 0,               16'h0000, 16'h0000, 16'h0000, 1'b0};
      vecs[3] = '{17,   0,   1'b0, PADON ? 60 : 59, 16'h002D, 16'h0019, 16'h0000, 1'b0};
      vecs[4] = '{18,   1,   1'b0, 60,              16'h002E, 16'h001A, 16'h0000, 1'b0};
      vecs[5] = '{1472, 0,   1'b0, 1514,            16'h05DC, 16'h05C8, 16'h0000, 1'b0};
      vecs[6] = '{1,    100, 1'b0, PADON ? 60 : 43, 16'h001D, 16'h0009, 16'h0000, 1'b0};

      bus.LocalMAC = LMAC;  bus.RemoteMAC = RMAC;
      bus.LocalIP = LIP;    bus.RemoteIP = RIP;
      bus.LocalPort = LPORT; bus.RemotePort = RPORT;
      bus.Start = 1'b0; bus.PayloadLen = 11'd0; bus.ReqConfirm = 1'b0;
      expId = 16'h0000;

      repeat (3) tick();
      check("reset_outputs", {20'd0, bus.Busy, bus.ErrLen, bus.PldRd, bus.ReqOut,
                              bus.ValOut, bus.SoFOut, bus.EoFOut, bus.DataOut}, 32'd0);
      nRst = 1'b1;
      tick();

      for (int i = 0; i < 7; i++) begin
         if (vecs[i].expErr) begin
            runErr(vecs[i].len);
         end else begin
            runFrame(vecs[i].len, vecs[i].grantDly, vecs[i].expBytes, c0);
            check("tot_len", 32'(cap16(c0 + 16)), 32'(vecs[i].expTot));
            check("udp_len", 32'(cap16(c0 + 38)), 32'(vecs[i].expUdp));
            if (vecs[i].chkCsum) check("ip_csum", 32'(cap16(c0 + 24)), 32'(vecs[i].expCsum));
         end
      end

      // ID wrap: preload 0xFFFF, expect FFFF then 0000
      force dut.frameId = 16'hFFFF;
      tick();
      release dut.frameId;
      tick();
      expId = 16'hFFFF;
      runFrame(4, 0, PADON ? 60 : 46, c0);
      runFrame(4, 0, PADON ? 60 : 46, c0);

      // reset while header byte 20 is on the bus
      bus.PayloadLen = 11'd10;
      bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      n = 0;
      while (!bus.ReqOut && n < 20) begin tick(); n++; end
      bus.ReqConfirm = 1'b1;
      tick();
      bus.ReqConfirm = 1'b0;
      c0 = capQ.size() - 1;
      n = 0;
      while (capQ.size() - c0 < 21 && n < 100) begin tick(); n++; end
      check("byte20_reached", 32'(capQ.size() - c0), 32'd21);
      nRst = 1'b0;
      #1;
      check("reset_midframe", {20'd0, bus.Busy, bus.ErrLen, bus.PldRd, bus.ReqOut,
                               bus.ValOut, bus.SoFOut, bus.EoFOut, bus.DataOut}, 32'd0);
      repeat (2) tick();
      nRst = 1'b1;
      okv = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.ValOut || bus.ReqOut || bus.Busy) okv = 1'b0;
      end
      check("no_resume_after_reset", 32'(okv), 32'd1);
      expId = 16'h0000;
      runFrame(4, 2, PADON ? 60 : 46, c0);
      check("ip_csum_after_reset", 32'(cap16(c0 + 24)), 32'hAF6D);

      check("idle_outputs", 32'(idleBad), 32'd0);
      check("req_val_overlap", 32'(overlapCnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
